// File: rtl/video_pkg.sv
// Shared video constants, frame geometry and the frame writer state type.
package video_pkg;

    localparam int FRAME_WIDTH              = 640;
    localparam int FRAME_HEIGHT             = 480;
    localparam int DEF_INTERFACE_WIDTH_BITS = 128;
    localparam int DEF_INTERFACE_ADDR_BITS  = 26;
    localparam int DEF_BITS_PER_PIXEL       = 16;
    localparam int DEF_PIXELS_PER_WORD      = DEF_INTERFACE_WIDTH_BITS / DEF_BITS_PER_PIXEL;
    localparam int DEF_NUM_WORDS            = (FRAME_WIDTH * FRAME_HEIGHT) / DEF_PIXELS_PER_WORD;
    localparam int DEF_ACK_TIMEOUT          = 1024;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2
    } fw_state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int index_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_writer_if.sv
// Memory bridge write port driven by the frame writer.
interface frame_writer_if
    import video_pkg::*;
#(
    parameter int ADDR_BITS = DEF_INTERFACE_ADDR_BITS,
    parameter int DATA_BITS = DEF_INTERFACE_WIDTH_BITS
) ();

    logic [ADDR_BITS-1:0]   interface_address;
    logic [DATA_BITS/8-1:0] interface_byte_enable;
    logic                   interface_read;
    logic                   interface_write;
    logic [DATA_BITS-1:0]   interface_write_data;
    logic                   interface_acknowledge;

    modport master (
        output interface_address,
        output interface_byte_enable,
        output interface_read,
        output interface_write,
        output interface_write_data,
        input  interface_acknowledge
    );

    modport slave (
        input  interface_address,
        input  interface_byte_enable,
        input  interface_read,
        input  interface_write,
        input  interface_write_data,
        output interface_acknowledge
    );

endinterface

// File: rtl/frame_writer_pixel_packer.sv
// Packs raster-order pixels into one bridge word; pixel 0 ends up in the lowest lane.
module pixel_packer
    import video_pkg::*;
#(
    parameter int WORD_BITS  = DEF_INTERFACE_WIDTH_BITS,
    parameter int PIXEL_BITS = DEF_BITS_PER_PIXEL
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  pixel_xfer,
    input  logic [PIXEL_BITS-1:0] pixel_data,
    output logic [WORD_BITS-1:0]  word_data,
    output logic                  pack_done
);

    localparam int PIXELS_PER_WORD = WORD_BITS / PIXEL_BITS;
    localparam int IDX_BITS        = index_bits(PIXELS_PER_WORD);
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(PIXELS_PER_WORD - 1);

    logic [IDX_BITS-1:0]  idx_q;
    logic [WORD_BITS-1:0] word_q;

    assign pack_done = pixel_xfer && (idx_q == LAST_IDX);
    assign word_data = word_q;

    // Shift pixels in from the top so the first pixel of a word lands in the low lane.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            idx_q  <= '0;
            word_q <= '0;
        end else if (pixel_xfer) begin
            word_q <= {pixel_data, word_q[WORD_BITS-1:PIXEL_BITS]};
            idx_q  <= pack_done ? '0 : idx_q + 1'b1;
        end
    end

endmodule

// File: rtl/frame_writer.sv
// Frame writer: packs a pixel stream into bridge words and writes one frame per start.
// Optional build macro FRAME_WRITER_ACK_TIMEOUT_EN enables the acknowledge timeout
// (sticky timing_error and abort); without it the block waits forever for acknowledge.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for start, no bridge activity
// ST_FILL  | accepting pixels until a word is packed
// ST_WRITE | holding the packed word on the bridge until acknowledge
module frame_writer
    import video_pkg::*;
#(
    parameter int INTERFACE_WIDTH_BITS = DEF_INTERFACE_WIDTH_BITS,
    parameter int INTERFACE_ADDR_BITS  = DEF_INTERFACE_ADDR_BITS,
    parameter int BITS_PER_PIXEL       = DEF_BITS_PER_PIXEL,
    parameter int NUM_WORDS            = DEF_NUM_WORDS,
    parameter int ACK_TIMEOUT          = DEF_ACK_TIMEOUT
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [INTERFACE_ADDR_BITS-1:0] base_address,
    input  logic [BITS_PER_PIXEL-1:0]      pixel_data,
    input  logic                           pixel_valid,
    output logic                           pixel_ready,
    frame_writer_if.master                 bridge,
    output logic                           busy,
    output logic                           done,
    output logic                           timing_error,
    input  logic                           timing_error_reset
);

    localparam int WORD_IDX_BITS = index_bits(NUM_WORDS);
    localparam int BYTE_SHIFT    = $clog2(INTERFACE_WIDTH_BITS / 8);
    localparam logic [WORD_IDX_BITS-1:0] LAST_WORD = WORD_IDX_BITS'(NUM_WORDS - 1);

    fw_state_t                      state_q;
    fw_state_t                      state_d;
    logic [INTERFACE_ADDR_BITS-1:0] base_q;
    logic [WORD_IDX_BITS-1:0]       word_idx_q;
    logic                           done_q;
    logic                           write_active;
    logic                           start_accept;
    logic                           pixel_xfer;
    logic                           pack_done;
    logic                           ack_seen;
    logic                           last_word;
    logic                           timeout_hit;
    logic [INTERFACE_WIDTH_BITS-1:0] word_data;

    assign start_accept = (state_q == ST_IDLE) && start;
    assign pixel_xfer   = pixel_ready && pixel_valid;
    assign ack_seen     = (state_q == ST_WRITE) && bridge.interface_acknowledge;
    assign last_word    = (word_idx_q == LAST_WORD);

    pixel_packer #(
        .WORD_BITS  (INTERFACE_WIDTH_BITS),
        .PIXEL_BITS (BITS_PER_PIXEL)
    ) u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_accept),
        .pixel_xfer (pixel_xfer),
        .pixel_data (pixel_data),
        .word_data  (word_data),
        .pack_done  (pack_done)
    );

`ifdef FRAME_WRITER_ACK_TIMEOUT_EN
    localparam int TMO_BITS = index_bits(ACK_TIMEOUT);
    localparam logic [TMO_BITS-1:0] TMO_LOAD = TMO_BITS'(ACK_TIMEOUT - 1);

    logic [TMO_BITS-1:0] tmo_cnt_q;
    logic                timing_error_q;

    assign timeout_hit  = (state_q == ST_WRITE) && !bridge.interface_acknowledge
                          && (tmo_cnt_q == '0);
    assign timing_error = timing_error_q;

    // Down-count WRITE cycles without acknowledge; a fresh abort wins over a clear request.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_q      <= TMO_LOAD;
            timing_error_q <= 1'b0;
        end else begin
            if (state_q != ST_WRITE) begin
                tmo_cnt_q <= TMO_LOAD;
            end else if (tmo_cnt_q != '0) begin
                tmo_cnt_q <= tmo_cnt_q - 1'b1;
            end
            if (timeout_hit) begin
                timing_error_q <= 1'b1;
            end else if (timing_error_reset) begin
                timing_error_q <= 1'b0;
            end
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg   = timing_error_reset | (ACK_TIMEOUT < 1);
    assign timeout_hit  = 1'b0;
    assign timing_error = 1'b0;
`endif

    // State register plus frame base, word index and the one-cycle done flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            word_idx_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= ack_seen && last_word;
            if (start_accept) begin
                base_q     <= base_address;
                word_idx_q <= '0;
            end else if (ack_seen) begin
                word_idx_q <= word_idx_q + 1'b1;
            end
        end
    end

    // Next state and per-state handshake outputs.
    always_comb begin
        state_d      = state_q;
        pixel_ready  = 1'b0;
        write_active = 1'b0;
        busy         = 1'b1;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                pixel_ready = 1'b1;
                if (pack_done) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                write_active = 1'b1;
                if (bridge.interface_acknowledge) begin
                    state_d = last_word ? ST_IDLE : ST_FILL;
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bridge.interface_address     = base_q
                                          + (INTERFACE_ADDR_BITS'(word_idx_q) << BYTE_SHIFT);
    assign bridge.interface_byte_enable = '1;
    assign bridge.interface_read        = 1'b0;
    assign bridge.interface_write       = write_active;
    assign bridge.interface_write_data  = word_data;
    assign done                         = done_q;

endmodule

// File: tb/tb_frame_writer.sv
// Randomized self-checking bench for frame_writer with a behavioural frame model.
// With FRAME_WRITER_ACK_TIMEOUT_EN defined the acknowledge timeout is exercised too.
module tb_frame_writer;

    localparam int NW   = 48;
    localparam int WB   = 128;
    localparam int AB   = 26;
    localparam int BPP  = 16;
    localparam int PPW  = WB / BPP;
    localparam int TMO  = 1024;
    localparam int NPIX = NW * PPW;

    logic          clk;
    logic          reset;
    logic          start;
    logic [AB-1:0] base_address;
    logic [BPP-1:0] pixel_data;
    logic          pixel_valid;
    logic          pixel_ready;
    logic          busy;
    logic          done;
    logic          timing_error;
    logic          timing_error_reset;

    frame_writer_if #(.ADDR_BITS(AB), .DATA_BITS(WB)) bridge ();

    frame_writer #(
        .INTERFACE_WIDTH_BITS (WB),
        .INTERFACE_ADDR_BITS  (AB),
        .BITS_PER_PIXEL       (BPP),
        .NUM_WORDS            (NW),
        .ACK_TIMEOUT          (TMO)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .base_address       (base_address),
        .pixel_data         (pixel_data),
        .pixel_valid        (pixel_valid),
        .pixel_ready        (pixel_ready),
        .bridge             (bridge),
        .busy               (busy),
        .done               (done),
        .timing_error       (timing_error),
        .timing_error_reset (timing_error_reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Frame model: pixel sequence, base, and the words the bridge must see.
    logic [BPP-1:0] px [0:NPIX-1];
    logic [AB-1:0]  m_base;
    logic [AB-1:0]  obs_addr [0:NW-1];
    logic [WB-1:0]  obs_data [0:NW-1];

    function automatic logic [AB-1:0] exp_addr(input logic [AB-1:0] base, input int k);
        longint a;
        a = (longint'(base) + longint'(k) * 16) % 64'sd67108864;
        return AB'(a);
    endfunction

    function automatic logic [WB-1:0] exp_data(input int k);
        logic [WB-1:0] d;
        d = '0;
        for (int j = 0; j < PPW; j++) d[BPP*j +: BPP] = px[PPW*k + j];
        return d;
    endfunction

    // Pixel source
    bit drv_en = 0;
    bit valid_always = 1;
    int px_ptr = 0;

    always @(negedge clk) begin
        bit pv;
        if (drv_en && px_ptr < NPIX) begin
            pv = valid_always ? 1'b1 : ($urandom_range(0, 3) != 0);
            pixel_valid = pv;
            pixel_data  = px[px_ptr];
            if (pv && pixel_ready) px_ptr++;
        end else begin
            pixel_valid = 1'b0;
            pixel_data  = BPP'($urandom);
        end
    end

    // Compare process and bridge responder
    bit            mon_en = 0;
    bit            in_write = 0;
    bit            ack_pending = 0;
    bit            ack_noise = 0;
    int            ack_fixed = 0;
    int            ack_delay_cur = 0;
    int            ack_wait = 0;
    int            cur_len = 0;
    int            first_len = 0;
    int            words_done = 0;
    int            done_count = 0;
    int            timeouts = 0;
    logic [AB-1:0] cap_addr;
    logic [WB-1:0] cap_data;

    always @(negedge clk) begin
        bit acked_last;
        acked_last = 1'b0;
        if (mon_en) begin
            chk("read_low", bridge.interface_read, 0);
`ifndef FRAME_WRITER_ACK_TIMEOUT_EN
            chk("timing_error_tied", timing_error, 0);
`endif
            if (ack_pending) begin
                ack_pending = 0;
                in_write    = 0;
                chk("write_drop_after_ack", bridge.interface_write, 0);
                if (words_done == NW) begin
                    acked_last = 1'b1;
                    chk("busy_at_done", busy, 0);
                    chk("ready_at_done", pixel_ready, 0);
                end else begin
                    chk("zero_bubble_ready", pixel_ready, 1);
                    chk("busy_between_words", busy, 1);
                end
            end else if (in_write && !bridge.interface_write) begin
                in_write = 0;
`ifdef FRAME_WRITER_ACK_TIMEOUT_EN
                timeouts++;
                chk("timeout_cycles", ack_wait, TMO);
                chk("timeout_error_set", timing_error, 1);
                chk("timeout_idle", busy, 0);
`else
                chk("write_held_until_ack", bridge.interface_write, 1);
`endif
            end
            chk("done_pulse", done, acked_last);
            if (done) done_count++;
            if (bridge.interface_write) begin
                chk("ready_in_write", pixel_ready, 0);
                chk("busy_in_write", busy, 1);
                if (!in_write) begin
                    in_write = 1;
                    ack_wait = 0;
                    cur_len  = 0;
                    if (words_done >= NW) begin
                        chk("extra_write_words", words_done, NW - 1);
                    end else begin
                        chk("addr", bridge.interface_address, exp_addr(m_base, words_done));
                        chk("data", bridge.interface_write_data, exp_data(words_done));
                        chk("byte_enable", bridge.interface_byte_enable, 16'hFFFF);
                        obs_addr[words_done] = bridge.interface_address;
                        obs_data[words_done] = bridge.interface_write_data;
                    end
                    cap_addr = bridge.interface_address;
                    cap_data = bridge.interface_write_data;
                    ack_delay_cur = (ack_fixed >= 0) ? ack_fixed : int'($urandom_range(0, 4));
                end else begin
                    chk("addr_stable", bridge.interface_address, cap_addr);
                    chk("data_stable", bridge.interface_write_data, cap_data);
                end
                cur_len++;
                if (ack_wait >= ack_delay_cur) begin
                    bridge.interface_acknowledge = 1'b1;
                    ack_pending = 1;
                    if (words_done == 0) first_len = cur_len;
                    words_done++;
                end else begin
                    bridge.interface_acknowledge = 1'b0;
                    ack_wait++;
                end
            end else begin
                bridge.interface_acknowledge = ack_noise && ($urandom_range(0, 3) == 0);
            end
        end else begin
            bridge.interface_acknowledge = 1'b0;
        end
    end

    task automatic setup_frame(input logic [AB-1:0] base, input bit inc_pattern, input int ack_mode,
                               input bit all_valid, input bit noise);
        for (int i = 0; i < NPIX; i++) px[i] = inc_pattern ? BPP'(i + 1) : BPP'($urandom);
        m_base       = base;
        words_done   = 0;
        in_write     = 0;
        ack_pending  = 0;
        ack_fixed    = ack_mode;
        ack_noise    = noise;
        valid_always = all_valid;
        px_ptr       = 0;
        drv_en       = 1;
        mon_en       = 1;
        @(negedge clk);
        start        = 1'b1;
        base_address = base;
        @(negedge clk);
        start        = 1'b0;
        base_address = AB'($urandom);
    endtask

    task automatic run_frame(input logic [AB-1:0] base, input bit inc_pattern, input int ack_mode,
                             input bit all_valid, input bit noise, input bit stray);
        int prev;
        bit got;
        prev = done_count;
        setup_frame(base, inc_pattern, ack_mode, all_valid, noise);
        got = 0;
        for (int c = 0; c < 20000 && !got; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done_count != prev) begin
                got = 1;
            end else if (stray && busy && $urandom_range(0, 15) == 0) begin
                start        = 1'b1;
                base_address = AB'($urandom);
            end
        end
        start = 1'b0;
        chk("frame_completes", got, 1);
        chk("done_once", done_count - prev, 1);
        @(negedge clk);
        chk("busy_after_done", busy, 0);
        chk("all_pixels_consumed", px_ptr, NPIX);
        chk("words_written", words_done, NW);
        drv_en = 0;
    endtask

    initial begin
        bit            got;
        logic [AB-1:0] b;
        reset              = 1'b1;
        start              = 1'b0;
        base_address       = '0;
        timing_error_reset = 1'b0;
        bridge.interface_acknowledge = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_ready", pixel_ready, 0);
        chk("reset_write", bridge.interface_write, 0);
        chk("reset_done", done, 0);
        chk("reset_timing_error", timing_error, 0);
        chk("reset_read", bridge.interface_read, 0);
        reset = 1'b0;
        @(negedge clk);

        // Single-word pattern: pixels 1..8, acknowledge after three waiting cycles.
        run_frame(26'h100, 1'b1, 3, 1'b1, 1'b0, 1'b0);
        chk("pin_word0_addr", obs_addr[0], 26'h100);
        chk("pin_word0_data", obs_data[0], 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        chk("pin_word0_write_cycles", first_len, 4);
        chk("pin_model_frame_end", exp_addr(26'h0, 38399), 26'h95FF0);

        // Full frame, immediate acknowledge, continuous pixels.
        b = AB'($urandom);
        run_frame(b, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        chk("last_word_addr", obs_addr[NW-1], exp_addr(b, NW - 1));

        // Backpressure: acknowledge held off for 50 cycles on every word.
        run_frame(AB'($urandom), 1'b0, 50, 1'b0, 1'b1, 1'b0);

        // Address wrap at the top of the bridge space.
        run_frame(26'h3FFFFF0, 1'b0, -1, 1'b0, 1'b1, 1'b0);
        chk("wrap_word0_addr", obs_addr[0], 26'h3FFFFF0);
        chk("wrap_word1_addr", obs_addr[1], 26'h0000000);

        // Start pulses while busy must not disturb the frame in flight.
        run_frame(AB'($urandom), 1'b0, -1, 1'b0, 1'b1, 1'b1);

        // Reset while a write is outstanding.
        setup_frame(AB'($urandom), 1'b0, 1000000, 1'b1, 1'b0);
        got = 0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if (bridge.interface_write) got = 1;
        end
        chk("reached_write", got, 1);
        repeat (2) @(negedge clk);
        mon_en = 0;
        drv_en = 0;
        reset  = 1'b1;
        @(negedge clk);
        chk("rst_mid_write_write", bridge.interface_write, 0);
        chk("rst_mid_write_busy", busy, 0);
        chk("rst_mid_write_ready", pixel_ready, 0);
        chk("rst_mid_write_done", done, 0);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("no_resume_busy", busy, 0);
            chk("no_resume_write", bridge.interface_write, 0);
            chk("no_resume_done", done, 0);
        end

        // A fresh frame after the reset starts from word 0 with the new base.
        run_frame(AB'($urandom), 1'b0, -1, 1'b0, 1'b1, 1'b0);

`ifdef FRAME_WRITER_ACK_TIMEOUT_EN
        begin
            int prev_done;
            prev_done = done_count;
            setup_frame(AB'($urandom), 1'b0, 1000000, 1'b1, 1'b0);
            got = 0;
            for (int c = 0; c < 3000 && !got; c++) begin
                @(negedge clk);
                if (!busy) got = 1;
            end
            chk("timeout_abort", got, 1);
            @(negedge clk);
            chk("timeout_seen", timeouts, 1);
            chk("timeout_no_done", done_count - prev_done, 0);
            drv_en = 0;
            repeat (5) @(negedge clk);
            chk("timing_error_sticky", timing_error, 1);
            timing_error_reset = 1'b1;
            @(negedge clk);
            timing_error_reset = 1'b0;
            chk("timing_error_cleared", timing_error, 0);
        end
`endif

        mon_en = 0;
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
